ldm_stm_sequencer: RTL and testbench

- Multi-cycle sequencer for ARM block transfers (LDM/STM). Walks a 16-bit register list and issues one word transfer per handshake.
- Drives the register-file transfer address and write port: load data goes to the write port, store data comes from the store read port.
- Produces the optional base-register writeback.
- Sits between decode/control and the register file/data-memory interface; holds the core busy for the duration of the transfer.

---
 rtl/ldm_stm_pkg.sv | 22 ++
 rtl/lowest_set_bit16.sv | 22 ++
 rtl/ldm_stm_sequencer.sv | 164 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
// Contents: FSM state enum, {P,U} addressing-mode encodings, word size, PC number.
// No ports; imported by ldm_stm_sequencer.
package ldm_stm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_WB,
    ST_DONE
  } state_t;

  // Addressing modes as the {P,U} bit pair.
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] PC_REG     = 4'd15;

endpackage

// File: rtl/lowest_set_bit16.sv
// Priority encoder: index of the lowest set bit of a 16-bit mask.
// Ports: mask in; index out (0 when mask is empty); valid out (mask nonzero).
// Purely combinational.
module lowest_set_bit16 (
  input  logic [15:0] mask,
  output logic [3:0]  index,
  output logic        valid
);

  // Scan from the top down so the last hit, the lowest bit, wins.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) begin
        index = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ARM LDM/STM sequencer: walks a register list, one word transfer per mem_ready cycle,
// then an optional base writeback and a one-cycle done pulse.
// Ports: clk/reset; start + instruction fields (is_load, P, U, W, base_reg, base_value,
// reg_list); register-file side (store_data, xfer_reg_addr, reg_write_*, base_write_*,
// pc_load); memory side (mem_req, mem_write, mem_addr, mem_write_data, mem_ready,
// mem_read_data); status (busy, done).
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  pre_index,
  input  logic                  up,
  input  logic                  writeback,
  input  logic [3:0]            base_reg,
  input  logic [DATA_WIDTH-1:0] base_value,
  input  logic [REG_COUNT-1:0]  reg_list,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [3:0]            xfer_reg_addr,
  output logic                  reg_write_enable,
  output logic [DATA_WIDTH-1:0] reg_write_data,
  output logic                  base_write_enable,
  output logic [DATA_WIDTH-1:0] base_write_data,
  output logic                  pc_load
);

  localparam int CNT_W = $clog2(REG_COUNT + 1);

  state_t                state, state_next;
  logic                  lat_load;
  logic                  lat_wb_en;
  logic [3:0]            lat_base_reg;
  logic [REG_COUNT-1:0]  remaining_mask;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wb_value;

  logic [3:0]            lsb_idx;
  logic                  lsb_vld;
  logic [CNT_W-1:0]      list_count;
  logic [DATA_WIDTH-1:0] list_bytes;
  logic [DATA_WIDTH-1:0] word_step;
  logic [DATA_WIDTH-1:0] start_addr;
  logic [DATA_WIDTH-1:0] start_wb;
  logic                  last_word;

  lowest_set_bit16 u_lsb (
    .mask  (remaining_mask),
    .index (lsb_idx),
    .valid (lsb_vld)
  );

  // Block geometry computed from the live inputs, used only on the start cycle.
  always_comb begin
    list_count = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      list_count = list_count + CNT_W'(reg_list[i]);
    end
    word_step  = DATA_WIDTH'(WORD_BYTES);
    list_bytes = DATA_WIDTH'(list_count) * word_step;
    // Registers always ascend in memory, so decrementing modes start at the
    // bottom of the block and still walk upwards.
    case ({pre_index, up})
      MODE_IA: start_addr = base_value;
      MODE_IB: start_addr = base_value + word_step;
      MODE_DA: start_addr = base_value - list_bytes + word_step;
      MODE_DB: start_addr = base_value - list_bytes;
      default: start_addr = base_value;
    endcase
    start_wb = up ? (base_value + list_bytes) : (base_value - list_bytes);
  end

  // Only one bit left means this handshake finishes the list.
  assign last_word = (remaining_mask & (remaining_mask - REG_COUNT'(1))) == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      lat_load       <= 1'b0;
      lat_wb_en      <= 1'b0;
      lat_base_reg   <= '0;
      remaining_mask <= '0;
      addr_q         <= '0;
      wb_value       <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) begin
        lat_load       <= is_load;
        // A load that includes the base keeps the loaded value instead.
        lat_wb_en      <= writeback & ~(is_load & reg_list[base_reg]);
        lat_base_reg   <= base_reg;
        remaining_mask <= reg_list;
        addr_q         <= start_addr;
        wb_value       <= start_wb;
      end else if (state == ST_XFER && mem_ready) begin
        remaining_mask <= remaining_mask & ~(REG_COUNT'(1) << lsb_idx);
        addr_q         <= addr_q + word_step;
      end
    end
  end

  always_comb begin
    state_next        = state;
    busy              = 1'b0;
    done              = 1'b0;
    mem_req           = 1'b0;
    mem_write         = 1'b0;
    mem_addr          = '0;
    xfer_reg_addr     = '0;
    reg_write_enable  = 1'b0;
    base_write_enable = 1'b0;
    base_write_data   = '0;
    pc_load           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (reg_list == '0) ? ST_DONE : ST_XFER;
        end
      end
      ST_XFER: begin
        busy          = 1'b1;
        mem_req       = lsb_vld;
        mem_write     = lsb_vld & ~lat_load;
        mem_addr      = addr_q;
        xfer_reg_addr = lsb_idx;
        if (mem_ready) begin
          reg_write_enable = lat_load;
          pc_load          = lat_load && (lsb_idx == PC_REG);
          if (last_word) begin
            state_next = lat_wb_en ? ST_WB : ST_DONE;
          end
        end
      end
      ST_WB: begin
        busy              = 1'b1;
        base_write_enable = 1'b1;
        xfer_reg_addr     = lat_base_reg;
        base_write_data   = wb_value;
        state_next        = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_write_data = store_data;
  assign reg_write_data = mem_read_data;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer: directed LDM/STM scenarios with a
// scoreboard of expected register/memory/writeback/done events.
// Emulates the register file read port and a data memory combinationally.
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        pre_index = 1'b0;
  logic        up = 1'b0;
  logic        writeback = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_value = '0;
  logic [15:0] reg_list = '0;
  logic [31:0] store_data;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_read_data;
  logic        busy, done, mem_req, mem_write;
  logic [31:0] mem_addr, mem_write_data, reg_write_data, base_write_data;
  logic [3:0]  xfer_reg_addr;
  logic        reg_write_enable, base_write_enable, pc_load;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  kind;   // 0 load write, 1 store, 2 base writeback, 3 done
    logic [3:0]  r;
    logic [31:0] addr;
    logic [31:0] data;
    logic        pc;
  } ev_t;

  ev_t exp_q[$];

  ldm_stm_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .is_load           (is_load),
    .pre_index         (pre_index),
    .up                (up),
    .writeback         (writeback),
    .base_reg          (base_reg),
    .base_value        (base_value),
    .reg_list          (reg_list),
    .store_data        (store_data),
    .mem_ready         (mem_ready),
    .mem_read_data     (mem_read_data),
    .busy              (busy),
    .done              (done),
    .mem_req           (mem_req),
    .mem_write         (mem_write),
    .mem_addr          (mem_addr),
    .mem_write_data    (mem_write_data),
    .xfer_reg_addr     (xfer_reg_addr),
    .reg_write_enable  (reg_write_enable),
    .reg_write_data    (reg_write_data),
    .base_write_enable (base_write_enable),
    .base_write_data   (base_write_data),
    .pc_load           (pc_load)
  );

  always #5 clk = ~clk;

  // Register Rn holds 0xA000_000n; memory word at a holds a ^ 0x5A5AA5A5.
  assign store_data    = 32'hA000_0000 | {28'd0, xfer_reg_addr};
  assign mem_read_data = mem_addr ^ 32'h5A5A_A5A5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input ev_t obs, input ev_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_load(input logic [3:0] r, input logic [31:0] a);
    exp_q.push_back({2'd0, r, a, a ^ 32'h5A5A_A5A5, r == 4'd15});
  endtask

  task automatic exp_store(input logic [3:0] r, input logic [31:0] a);
    exp_q.push_back({2'd1, r, a, 32'hA000_0000 | {28'd0, r}, 1'b0});
  endtask

  task automatic exp_wb(input logic [3:0] r, input logic [31:0] d);
    exp_q.push_back({2'd2, r, 32'd0, d, 1'b0});
  endtask

  task automatic exp_done();
    exp_q.push_back({2'd3, 4'd0, 32'd0, 32'd0, 1'b0});
  endtask

  task automatic observe(input ev_t o);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL unexpected_event: observed %h expected none", o);
    end else begin
      e = exp_q.pop_front();
      chk_ev("event", o, e);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (reg_write_enable) begin
      chk("rwe_only_on_ready", 32'(mem_ready), 32'd1);
      observe({2'd0, xfer_reg_addr, mem_addr, reg_write_data, pc_load});
    end
    if (mem_write && mem_ready)
      observe({2'd1, xfer_reg_addr, mem_addr, mem_write_data, 1'b0});
    if (base_write_enable)
      observe({2'd2, xfer_reg_addr, 32'd0, base_write_data, 1'b0});
    if (done)
      observe({2'd3, 4'd0, 32'd0, 32'd0, 1'b0});
    if (mem_req && !mem_ready)
      chk("stall_no_strobe", 32'({reg_write_enable, pc_load}), 32'd0);
    if (reg_write_enable || base_write_enable)
      chk("strobe_exclusive", 32'(reg_write_enable & base_write_enable), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic ld, input logic p, input logic u, input logic w,
                        input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
    is_load = ld; pre_index = p; up = u; writeback = w;
    base_reg = rn; base_value = base; reg_list = list;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called just after a rising edge; cycle numbering continues from 'first'.
  task automatic wait_done(input int budget, input int first, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = first + i;
        return;
      end
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({busy, done, mem_req, mem_write, reg_write_enable,
                            base_write_enable, pc_load}), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_xreg"}, 32'(xfer_reg_addr), 32'd0);
    chk({tag, "_bwd"}, base_write_data, 32'd0);
  endtask

  initial begin
    int cyc;

    // Reset state.
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // LDMIA base 0x100, {R1,R2,R3}, W=1.
    exp_load(4'd1, 32'h100); exp_load(4'd2, 32'h104); exp_load(4'd3, 32'h108);
    exp_wb(4'd0, 32'h10C); exp_done();
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 32'h100, 16'h000E);
    @(negedge clk);
    chk("ldmia_busy", 32'(busy), 32'd1);
    chk("ldmia_first_addr", mem_addr, 32'h100);
    tick();
    wait_done(20, 2, cyc);
    chk("ldmia_done_cycle", 32'(cyc), 32'd5);
    chk("ldmia_busy_at_done", 32'(busy), 32'd0);
    tick();

    // STMDB base 0x200, {R0,R1,R14}, W=1; a start while busy is ignored.
    exp_store(4'd0, 32'h1F4); exp_store(4'd1, 32'h1F8); exp_store(4'd14, 32'h1FC);
    exp_wb(4'd13, 32'h1F4); exp_done();
    launch(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h4003);
    start = 1'b1; reg_list = 16'hFFFF; base_value = 32'h900;
    tick();
    start = 1'b0;
    wait_done(20, 2, cyc);
    chk("stmdb_done_cycle", 32'(cyc), 32'd5);
    tick();

    // LDMIB base 0x40, {R0,R15}, two stall cycles before each word.
    mem_ready = 1'b0;
    exp_load(4'd0, 32'h44); exp_load(4'd15, 32'h48); exp_done();
    launch(1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 32'h40, 16'h8001);
    @(negedge clk);
    chk("ldmib_req_stalled", 32'(mem_req), 32'd1);
    chk("ldmib_addr0", mem_addr, 32'h44);
    tick();
    @(negedge clk);
    chk("ldmib_addr0_hold", mem_addr, 32'h44);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("ldmib_addr1", mem_addr, 32'h48);
    chk("ldmib_xreg1", 32'(xfer_reg_addr), 32'd15);
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    wait_done(10, 7, cyc);
    chk("ldmib_done_cycle", 32'(cyc), 32'd7);
    tick();

    // LDMDA base 0x80, base_reg R2 in list {R2}: single load, no writeback.
    exp_load(4'd2, 32'h80); exp_done();
    launch(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 32'h80, 16'h0004);
    wait_done(10, 1, cyc);
    chk("ldmda_done_cycle", 32'(cyc), 32'd2);
    tick();

    // Empty list, and a second start during DONE that must be ignored.
    exp_done();
    launch(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 32'h500, 16'h0000);
    start = 1'b1; reg_list = 16'h0001;
    wait_done(5, 1, cyc);
    chk("empty_done_cycle", 32'(cyc), 32'd1);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_quiet", 32'({busy, mem_req}), 32'd0);
      tick();
    end

    // Reset during the second word of a 4-register LDMIA.
    exp_load(4'd4, 32'h300); exp_load(4'd5, 32'h304);
    launch(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'h300, 16'h00F0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (4) tick();

    // Fresh transfer after the abandoned one.
    exp_load(4'd0, 32'h400); exp_load(4'd1, 32'h404);
    exp_wb(4'd6, 32'h408); exp_done();
    launch(1'b1, 1'b0, 1'b1, 1'b1, 4'd6, 32'h400, 16'h0003);
    wait_done(10, 1, cyc);
    chk("post_reset_done_cycle", 32'(cyc), 32'd4);
    tick();
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not complete in time");
  end

endmodule
